// File: rtl/cpu_ififo_pkg.sv
// cpu_ififo shared definitions: widths and the
// opcode-with-immediate table used by the decoder.
package cpu_ififo_pkg;

    localparam int HW_W   = 16;
    localparam int WORD_W = 32;
    localparam int N_OPS  = 17;

    localparam logic [7:0] OPERAND_OPS [N_OPS] = '{
        8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D,
        8'h1A, 8'h1B, 8'h1D, 8'h1F, 8'h20, 8'h22,
        8'h24, 8'h36, 8'h37, 8'h38, 8'h39
    };

    function automatic logic has_operand(
        input logic [HW_W-1:0] op
    );
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_OPS; i++) begin
            if (op[15:8] == OPERAND_OPS[i]) begin
                hit = 1'b1;
            end
        end
        return !op[15] && hit;
    endfunction

endpackage

// File: rtl/cpu_ififo_if.sv
// Fetch/decode side bundle of the instruction FIFO.
// master drives pushes/pops, slave is the FIFO.
interface cpu_ififo_if;
    import cpu_ififo_pkg::*;

    logic              write_en_i;
    logic              read_en_i;
    logic [WORD_W-1:0] data_i;
    logic [HW_W-1:0]   opcode_o;
    logic [WORD_W-1:0] operand_o;
    logic              valid_o;
    logic              empty_o;
    logic              full_o;

    modport master (
        output write_en_i, read_en_i, data_i,
        input  opcode_o, operand_o, valid_o,
        input  empty_o, full_o
    );

    modport slave (
        input  write_en_i, read_en_i, data_i,
        output opcode_o, operand_o, valid_o,
        output empty_o, full_o
    );

endinterface

// File: rtl/cpu_ififo.sv
// Halfword instruction FIFO: 32-bit big-endian pushes,
// show-ahead opcode plus optional 32-bit immediate.
module cpu_ififo
    import cpu_ififo_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input logic        clk_i,
    input logic        rst_i,
    cpu_ififo_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [HW_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]   r_rd;
    logic [AW-1:0]   r_wr;
    logic [CW-1:0]   r_count;

    logic [AW-1:0]   w_rd1;
    logic [AW-1:0]   w_rd2;
    logic [AW-1:0]   w_wr1;
    logic [HW_W-1:0] w_head;
    logic            w_has_op;
    logic [CW-1:0]   w_len;
    logic            w_valid;
    logic            w_wr_ok;
    logic            w_rd_ok;

    assign w_rd1    = r_rd + AW'(1);
    assign w_rd2    = r_rd + AW'(2);
    assign w_wr1    = r_wr + AW'(1);
    assign w_head   = r_mem[r_rd];
    assign w_has_op = has_operand(w_head);
    assign w_len    = w_has_op ? CW'(3) : CW'(1);
    assign w_valid  = (r_count != '0) && (r_count >= w_len);

    // Room for a whole word is judged on the pre-edge count.
    assign w_wr_ok = bus.write_en_i && (r_count <= CW'(DEPTH - 2));
    assign w_rd_ok = bus.read_en_i && w_valid;

    assign bus.valid_o   = w_valid;
    assign bus.empty_o   = (r_count == '0);
    assign bus.full_o    = (r_count > CW'(DEPTH - 4));
    assign bus.opcode_o  = w_valid ? w_head : '0;
    assign bus.operand_o = (w_valid && w_has_op)
                         ? {r_mem[w_rd1], r_mem[w_rd2]}
                         : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_ok) begin
                r_mem[r_wr]  <= bus.data_i[31:16];
                r_mem[w_wr1] <= bus.data_i[15:0];
                r_wr         <= r_wr + AW'(2);
            end
            if (w_rd_ok) begin
                r_rd <= r_rd + AW'(w_len);
            end
            r_count <= r_count
                     + (w_wr_ok ? CW'(2) : CW'(0))
                     - (w_rd_ok ? w_len : CW'(0));
        end
    end

endmodule

// File: tb/tb_cpu_ififo.sv
// Directed self-checking bench for cpu_ififo.
// Inputs change and outputs are sampled on the falling edge.
module tb_cpu_ififo;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    cpu_ififo_if bus ();

    cpu_ififo #(.DEPTH(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.write_en_i = 1'b0;
        bus.read_en_i  = 1'b0;
        bus.data_i     = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (bus.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", bus.valid_o);
        end
        checks++;
        if (bus.empty_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_empty got %b want 1", bus.empty_o);
        end
        checks++;
        if (bus.full_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_full got %b want 0", bus.full_o);
        end
        checks++;
        if (bus.opcode_o !== 16'h0000) begin
            errors++;
            $display("FAIL reset_opcode got %h want 0000", bus.opcode_o);
        end
        checks++;
        if (bus.operand_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_operand got %h want 0", bus.operand_o);
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.write_en_i = 1'b1;
        bus.data_i     = 32'h0F0F_2600;
        @(negedge clk);
        bus.write_en_i = 1'b0;
        checks++;
        if (bus.valid_o !== 1'b1 || bus.opcode_o !== 16'h0F0F) begin
            errors++;
            $display("FAIL single_first got v=%b op=%h want v=1 op=0f0f",
                     bus.valid_o, bus.opcode_o);
        end
        bus.read_en_i = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.valid_o !== 1'b1 || bus.opcode_o !== 16'h2600) begin
            errors++;
            $display("FAIL single_second got v=%b op=%h want v=1 op=2600",
                     bus.valid_o, bus.opcode_o);
        end
        @(negedge clk);
        bus.read_en_i = 1'b0;
        checks++;
        if (bus.valid_o !== 1'b0 || bus.empty_o !== 1'b1) begin
            errors++;
            $display("FAIL single_drain got v=%b e=%b want v=0 e=1",
                     bus.valid_o, bus.empty_o);
        end
    endtask

    task automatic test_operand();
        do_reset();
        bus.write_en_i = 1'b1;
        bus.data_i     = 32'h0120_1234;
        @(negedge clk);
        bus.write_en_i = 1'b0;
        checks++;
        if (bus.valid_o !== 1'b0 || bus.empty_o !== 1'b0
            || bus.opcode_o !== 16'h0) begin
            errors++;
            $display("FAIL operand_partial got v=%b e=%b op=%h want v=0 e=0 op=0000",
                     bus.valid_o, bus.empty_o, bus.opcode_o);
        end
        bus.write_en_i = 1'b1;
        bus.data_i     = 32'h5678_0000;
        @(negedge clk);
        bus.write_en_i = 1'b0;
        checks++;
        if (bus.valid_o !== 1'b1 || bus.opcode_o !== 16'h0120
            || bus.operand_o !== 32'h1234_5678) begin
            errors++;
            $display("FAIL operand_full got v=%b op=%h imm=%h want v=1 op=0120 imm=12345678",
                     bus.valid_o, bus.opcode_o, bus.operand_o);
        end
        bus.read_en_i = 1'b1;
        @(negedge clk);
        bus.read_en_i = 1'b0;
        checks++;
        if (bus.valid_o !== 1'b1 || bus.opcode_o !== 16'h0000
            || bus.operand_o !== 32'h0) begin
            errors++;
            $display("FAIL operand_next got v=%b op=%h imm=%h want v=1 op=0000 imm=0",
                     bus.valid_o, bus.opcode_o, bus.operand_o);
        end
    endtask

    task automatic test_full();
        logic [15:0] hi;
        logic [15:0] exp;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            hi = 16'h0F00 + 16'(2 * k);
            bus.write_en_i = 1'b1;
            bus.data_i = (k == 8) ? 32'hDEAD_BEEF : {hi, hi + 16'h1};
            @(negedge clk);
            if (k == 5) begin
                checks++;
                if (bus.full_o !== 1'b0) begin
                    errors++;
                    $display("FAIL full_at12 got %b want 0", bus.full_o);
                end
            end
            if (k == 6) begin
                checks++;
                if (bus.full_o !== 1'b1) begin
                    errors++;
                    $display("FAIL full_at14 got %b want 1", bus.full_o);
                end
            end
        end
        bus.write_en_i = 1'b0;
        bus.read_en_i  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp = 16'h0F00 + 16'(i);
            checks++;
            if (bus.valid_o !== 1'b1 || bus.opcode_o !== exp) begin
                errors++;
                $display("FAIL full_read%0d got v=%b op=%h want v=1 op=%h",
                         i, bus.valid_o, bus.opcode_o, exp);
            end
            @(negedge clk);
        end
        bus.read_en_i = 1'b0;
        checks++;
        if (bus.empty_o !== 1'b1 || bus.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL full_drain got e=%b v=%b want e=1 v=0",
                     bus.empty_o, bus.valid_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        logic [15:0] nxt;
        int          cyc;
        logic        saw_full;
        do_reset();
        exp      = 16'h0F00;
        nxt      = 16'h0F00;
        cyc      = 0;
        saw_full = 1'b0;
        while (exp != 16'h0F40 && cyc < 300) begin
            if (bus.full_o) saw_full = 1'b1;
            bus.read_en_i = 1'b0;
            if (bus.valid_o) begin
                checks++;
                if (bus.opcode_o !== exp) begin
                    errors++;
                    $display("FAIL b2b_order got %h want %h",
                             bus.opcode_o, exp);
                end
                bus.read_en_i = 1'b1;
                exp = exp + 16'h1;
            end
            bus.write_en_i = 1'b0;
            if (!bus.full_o && nxt != 16'h0F40) begin
                bus.write_en_i = 1'b1;
                bus.data_i     = {nxt, nxt + 16'h1};
                nxt = nxt + 16'h2;
            end
            @(negedge clk);
            cyc++;
        end
        bus.read_en_i  = 1'b0;
        bus.write_en_i = 1'b0;
        checks++;
        if (exp !== 16'h0F40) begin
            errors++;
            $display("FAIL b2b_timeout got %h want 0f40", exp);
        end
        checks++;
        if (saw_full !== 1'b1) begin
            errors++;
            $display("FAIL b2b_fill got %b want 1", saw_full);
        end
        checks++;
        if (bus.empty_o !== 1'b1 || bus.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end got e=%b v=%b want e=1 v=0",
                     bus.empty_o, bus.valid_o);
        end
    endtask

    task automatic test_flush();
        do_reset();
        bus.write_en_i = 1'b1;
        bus.data_i     = 32'h0F01_0F02;
        @(negedge clk);
        checks++;
        if (bus.valid_o !== 1'b1 || bus.opcode_o !== 16'h0F01) begin
            errors++;
            $display("FAIL flush_pre got v=%b op=%h want v=1 op=0f01",
                     bus.valid_o, bus.opcode_o);
        end
        rst         = 1'b1;
        bus.data_i  = 32'h0F03_0F04;
        @(negedge clk);
        rst            = 1'b0;
        bus.write_en_i = 1'b0;
        checks++;
        if (bus.empty_o !== 1'b1 || bus.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_post got e=%b v=%b want e=1 v=0",
                     bus.empty_o, bus.valid_o);
        end
        @(negedge clk);
        checks++;
        if (bus.empty_o !== 1'b1 || bus.opcode_o !== 16'h0) begin
            errors++;
            $display("FAIL flush_idle got e=%b op=%h want e=1 op=0000",
                     bus.empty_o, bus.opcode_o);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus.write_en_i = 1'b0;
        bus.read_en_i  = 1'b0;
        bus.data_i     = '0;
        test_reset();
        test_single();
        test_operand();
        test_full();
        test_back_to_back();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_ififo.md
Name: cpu_ififo

Overview:
- Instruction FIFO between the fetch unit and decode.
- Accepts 32-bit big-endian instruction-memory words and stores them as 16-bit halfwords.
- Presents the head instruction as a 16-bit opcode plus an optional 32-bit immediate operand, with a valid flag.
- Fetch flushes it on branches by pulsing rst_i.

Parameters:
- DEPTH, 16, storage capacity in halfwords; power of two, minimum 8.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset; also used as the branch flush.
- write_en_i  input  1  push data_i this cycle.
- read_en_i  input  1  consume the head instruction this cycle.
- data_i  input  32  fetched word; data_i[31:16] is the earlier halfword.
- opcode_o  output  16  head opcode halfword.
- operand_o  output  32  head immediate; the first following halfword occupies bits [31:16].
- valid_o  output  1  head instruction is completely present.
- empty_o  output  1  no halfwords stored.
- full_o  output  1  cannot guarantee room for two more words.

Behaviour:
- State is a halfword array[DEPTH], plus read pointer, write pointer and count (0..DEPTH).
- Pointers wrap modulo DEPTH.

Reset (rst_i=1 at the edge):
- Clears pointers and count; contents are don't-care.
- Takes priority over simultaneous write or read.
- Resulting outputs: valid_o=0, empty_o=1, full_o=0, opcode_o=0, operand_o=0.

Operand decode:
- An opcode carries a 32-bit operand iff opcode[15]=0 and opcode[15:8] is one of 0x01, 0x03, 0x08, 0x09, 0x0C, 0x0D, 0x1A, 0x1B, 0x1D, 0x1F, 0x20, 0x22, 0x24, 0x36, 0x37, 0x38, 0x39.
- All other opcodes, including all of form 2 and form 3, are 1 halfword.
- Instruction length L is 3 halfwords with an operand, 1 without.

Outputs (combinational from registered state, show-ahead):
- valid_o = count >= L of the head halfword.
- When valid_o=1:
  - opcode_o = mem[rd].
  - operand_o = {mem[rd+1], mem[rd+2]} if L=3, else 0.
- When valid_o=0: opcode_o=0 and operand_o=0.
- empty_o = (count==0).
- full_o = (count > DEPTH-4).
  - This leaves room for one in-flight word, because fetch registers its write enable one cycle after sampling full_o.

Write:
- If write_en_i=1 and count <= DEPTH-2, store data_i[31:16] at wr and data_i[15:0] at wr+1, then wr += 2.
- Otherwise the word is silently dropped; no partial write ever occurs.

Read:
- If read_en_i=1 and valid_o=1, rd += L.
- read_en_i with valid_o=0 is ignored; no underflow.

Simultaneous read and write in one cycle:
- count_next = count + 2·write_accepted − L·read_accepted.
- Write acceptance is judged on the pre-edge count.

Timing:
- A written word is visible at the outputs in the cycle after the write edge.
- An operand split across two words becomes valid only after the second word is written.

Decomposition:
- Package cpu_ififo_pkg holds:
  - The operand-opcode constant list.
  - A function has_operand(opcode[15:0]) returning 1 bit.
  - Localparams for halfword width (16) and word width (32).
- No sub-module; a single flat module.

Test Plan:
- Reset, then idle → valid_o=0, empty_o=1, full_o=0, opcode_o=0, operand_o=0.
- Write 0x0F0F_2600 (two 1-halfword opcodes), then read_en_i held → cycle+1: opcode_o=0x0F0F, valid_o=1; next cycle opcode_o=0x2600; then valid_o=0, empty_o=1.
- Write 0x0120_1234, then 0x5678_0000 (ldi.l) → after the first write valid_o=0 with empty_o=0; after the second, opcode_o=0x0120, operand_o=0x12345678, valid_o=1. Consume → head becomes 0x0000.
- Write 7 words with no reads (DEPTH=16) → full_o=1 once count=14. An 8th write is accepted (count 16) and a 9th is dropped (count stays 16); the read-out sequence equals the first 8 words.
- Fill past wrap with concurrent reads and writes of 1-halfword opcodes 0x0F00..0x0F3F → the output stream is in order with no loss or duplication; count stays consistent.
- Mid-stream, with valid_o=1, pulse rst_i together with write_en_i=1 → next cycle empty_o=1, valid_o=0, and the concurrent write is discarded.
